// File: rtl/uart_dmi.sv
// UART-to-DMI bridge: 8N1 host frames become single DMI requests; replies go back as status/data bytes.
// Latency: request issued the cycle after the last frame byte; reply starts two cycles after dmi_rsp_valid.
// Backpressure: request held until dmi_req_ready; host bytes arriving while busy are dropped. Option: UART_DMI__TIMEOUT_EN.
module uart_dmi #(
    parameter int ClockHz       = 50_000_000,
    parameter int BaudRate      = 115200,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 7,
    parameter int TimeoutCycles = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rx,
    output logic                    uart_tx,
    output logic                    dmi_req_valid,
    input  logic                    dmi_req_ready,
    output logic [1:0]              dmi_req_op,
    output logic [AddressWidth-1:0] dmi_req_addr,
    output logic [DataWidth-1:0]    dmi_req_data,
    input  logic                    dmi_rsp_valid,
    input  logic [1:0]              dmi_rsp_op,
    input  logic [DataWidth-1:0]    dmi_rsp_data
);

    localparam int          Div      = ClockHz / BaudRate;
    localparam logic [15:0] DivLast  = 16'(Div - 1);
    localparam logic [15:0] HalfLast = 16'(Div / 2 - 1);
    localparam logic [31:0] GapLast  = 32'(16 * Div * 10 - 1);
    localparam logic [1:0]  OpRead   = 2'd1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;
    localparam logic [2:0] S_TX   = 3'd5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    if (DataWidth != 32) begin : g_bad_data_width
        $error("uart_dmi: DataWidth must be 32");
    end
    if (AddressWidth < 1 || AddressWidth > 8) begin : g_bad_addr_width
        $error("uart_dmi: AddressWidth must be 1..8");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("uart_dmi: TimeoutCycles must be positive");
    end
    if (Div < 2) begin : g_bad_div
        $error("uart_dmi: ClockHz/BaudRate must be at least 2");
    end

    typedef struct packed {
        logic [1:0]              op;
        logic [AddressWidth-1:0] addr;
        logic [DataWidth-1:0]    data;
    } req_t;

    // ---------------- receive path ----------------
    logic       rx_meta, rx_sync, rx_prev;
    logic [1:0] rx_state;
    logic [15:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_byte_vld, rx_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_byte_vld  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_byte_vld  <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // mid-start re-check rejects glitches on the idle line
                    if (rx_cnt == HalfLast) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DivLast) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == DivLast) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) rx_byte_vld  <= 1'b1;
                        else         rx_frame_err <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // ---------------- transmit path ----------------
    logic [9:0]  tx_shift;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic        tx_busy, tx_rdy, tx_load;
    logic [7:0]  tx_byte;

    // ready on the final stop-bit cycle so the next start bit follows with no gap
    assign tx_rdy  = !tx_busy || (tx_bit == 4'd9 && tx_cnt == DivLast);
    assign uart_tx = tx_shift[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b0;
        end else if (tx_load) begin
            tx_shift <= {1'b1, tx_byte, 1'b0};
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == DivLast) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_bit  <= '0;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- frame / request sequencer ----------------
    logic [2:0]           state;
    req_t                 req;
    logic [1:0]           byte_idx;
    logic [31:0]          gap_cnt;
    logic                 gap_hit;
    logic [7:0]           rsp_status;
    logic [DataWidth-1:0] rsp_data;
    logic [2:0]           tx_idx, tx_total;

    assign gap_hit      = (gap_cnt == GapLast);
    assign tx_total     = (req.op == OpRead) ? 3'd5 : 3'd1;
    assign tx_load      = (state == S_TX) && tx_rdy && (tx_idx != tx_total);
    assign dmi_req_op   = req.op;
    assign dmi_req_addr = req.addr;
    assign dmi_req_data = req.data;

    always_comb begin
        tx_byte = rsp_status;
        case (tx_idx)
            3'd1:    tx_byte = rsp_data[7:0];
            3'd2:    tx_byte = rsp_data[15:8];
            3'd3:    tx_byte = rsp_data[23:16];
            3'd4:    tx_byte = rsp_data[31:24];
            default: tx_byte = rsp_status;
        endcase
    end

`ifdef UART_DMI__TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);
    logic [31:0] to_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            req           <= '0;
            byte_idx      <= '0;
            gap_cnt       <= '0;
            rsp_status    <= '0;
            rsp_data      <= '0;
            tx_idx        <= '0;
            dmi_req_valid <= 1'b0;
`ifdef UART_DMI__TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    gap_cnt <= '0;
                    if (rx_byte_vld && (rx_shift == 8'h01 || rx_shift == 8'h02)) begin
                        req.op   <= rx_shift[1:0];
                        req.data <= '0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_frame_err || gap_hit) begin
                        state <= S_IDLE;
                    end else if (rx_byte_vld) begin
                        req.addr <= rx_shift[AddressWidth-1:0];
                        gap_cnt  <= '0;
                        byte_idx <= '0;
                        if (req.op == OpRead) begin
                            state         <= S_REQ;
                            dmi_req_valid <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (rx_frame_err || gap_hit) begin
                        state <= S_IDLE;
                    end else if (rx_byte_vld) begin
                        req.data[{byte_idx, 3'b000} +: 8] <= rx_shift;
                        byte_idx <= byte_idx + 2'd1;
                        gap_cnt  <= '0;
                        if (byte_idx == 2'd3) begin
                            state         <= S_REQ;
                            dmi_req_valid <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                S_REQ: begin
                    if (dmi_req_ready) begin
                        dmi_req_valid <= 1'b0;
                        state         <= S_RSP;
`ifdef UART_DMI__TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end
                end
                S_RSP: begin
                    if (dmi_rsp_valid) begin
                        rsp_status <= {6'b0, dmi_rsp_op};
                        rsp_data   <= dmi_rsp_data;
                        tx_idx     <= '0;
                        state      <= S_TX;
                    end
`ifdef UART_DMI__TIMEOUT_EN
                    else if (to_cnt == TimeoutLast) begin
                        rsp_status <= 8'hFF;
                        rsp_data   <= '0;
                        tx_idx     <= '0;
                        state      <= S_TX;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                S_TX: begin
                    if (tx_load) begin
                        tx_idx <= tx_idx + 3'd1;
                    end else if (tx_rdy && tx_idx == tx_total) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_dmi.md
UART_DMI -- requirements
Module: uart_dmi

Interface
REQ-001 Parameter ClockHz, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BaudRate, default 115200, UART bit rate; divisor Div = ClockHz/BaudRate, integer-truncated.
REQ-003 Parameter DataWidth, default 32, DMI data width; SHALL be 32.
REQ-004 Parameter AddressWidth, default 7, DMI address width; SHALL be 1..8.
REQ-005 Parameter TimeoutCycles, default 65536, DMI response timeout in clk cycles.
REQ-006 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 uart_rx  input  1  host serial in, 8N1, idle high, asynchronous to clk.
REQ-009 uart_tx  output  1  host serial out, 8N1, idle high.
REQ-010 dmi_req_valid  output  1  DMI request valid.
REQ-011 dmi_req_ready  input  1  DMI request accepted by dm.
REQ-012 dmi_req_op  output  2  1 = read, 2 = write.
REQ-013 dmi_req_addr  output  AddressWidth  DMI register address.
REQ-014 dmi_req_data  output  DataWidth  write data.
REQ-015 dmi_rsp_valid  input  1  one-cycle response pulse from dm.
REQ-016 dmi_rsp_op  input  2  0 = ok, 2 = failed, 3 = busy.
REQ-017 dmi_rsp_data  input  DataWidth  read data.

Function
REQ-018 uart_rx double-flop synchronized before use.
REQ-019 RX: falling edge starts frame; start bit re-sampled at Div/2, abort if high; data bits LSB first at Div intervals; stop bit low = framing error, byte discarded and frame parser returns to S_IDLE.
REQ-020 Host frame: byte0 op (0x01 read, 0x02 write), byte1 address (low AddressWidth bits used, upper ignored), write only: 4 data bytes little-endian.
REQ-021 States: S_IDLE -> S_ADDR on valid op byte; other op values dropped, stay S_IDLE; S_ADDR -> S_REQ (read) or S_DATA (write); S_DATA -> S_REQ after 4th byte.
REQ-022 S_REQ: dmi_req_valid high with op/addr/data stable until cycle where dmi_req_ready is high; then S_RSP next cycle.
REQ-023 S_RSP: capture dmi_rsp_op/data on dmi_rsp_valid; dmi_rsp_valid in any other state ignored; rsp_valid in the same cycle as the req handshake ignored.
REQ-024 S_TX: send status byte (dmi_rsp_op zero-extended, or 0xFF on timeout), then for read only 4 data bytes little-endian; then S_IDLE.
REQ-025 TX: 1 start, 8 data LSB first, 1 stop, each exactly Div cycles; back-to-back bytes with no idle gap.
REQ-026 Inter-byte gap: in S_ADDR/S_DATA, if no byte completes within 16*Div*10 cycles, discard partial frame, return to S_IDLE, no response.
REQ-027 Bytes completed while in S_REQ/S_RSP/S_TX are discarded; no queueing.
REQ-028 Exactly one DMI request per accepted frame; no response for discarded frames.

Reset
REQ-029 On rst: uart_tx=1, dmi_req_valid=0, dmi_req_op=0, dmi_req_addr=0, dmi_req_data=0, state S_IDLE, all counters 0.
REQ-030 rst mid-frame or mid-request drops the transaction; dmi_req_valid deasserts asynchronously; uart_tx returns high immediately.

Configuration
REQ-031 Macro UART_DMI__TIMEOUT_EN defined: S_RSP counts cycles; on reaching TimeoutCycles without dmi_rsp_valid, status 0xFF, data 0, enter S_TX.
REQ-032 Macro undefined: S_RSP waits indefinitely; no timeout counter synthesized; status 0xFF never sent.

Verification
REQ-033 Write: send 02 10 78 56 34 12 -> one request op=2 addr=0x10 data=0x12345678; rsp ok -> host receives 00.
REQ-034 Read: send 01 11, dm returns ok data 0xDEADBEEF -> host receives 00 EF BE AD DE.
REQ-035 Backpressure: dmi_req_ready low 20 cycles -> req_valid/addr/data stable 20 cycles, single handshake.
REQ-036 Bad frame: op byte 0x7F, then 01 04 -> only one request (addr 0x04); stop bit 0 on byte1 -> no request.
REQ-037 Timeout (macro defined, TimeoutCycles=100): no rsp -> host receives FF 00 00 00 00 after read frame.
REQ-038 rst asserted during S_DATA -> uart_tx=1, no DMI request; next full frame processed normally.
